prog_loader: RTL and testbench

Boot-time program loader that writes instruction memory. Accepts a byte stream over a valid/ready handshake and parses a 16-bit little-endian word-count header. Packs the following bytes into little-endian 32-bit instruction words and issues one write per word at byte addresses BASE_ADDR, BASE_ADDR+4, and so on. Holds the CPU in reset until the image is fully loaded, replacing the fixed program contents with a downloadable image.

---
 rtl/prog_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_prog_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader for instruction memory. A byte stream arrives over
// a valid/ready handshake. The first two bytes are a 16-bit little-endian word
// count. Each following group of four bytes is packed LSB-first into one
// 32-bit instruction word and written at BASE_ADDR, BASE_ADDR+4, and so on.
// The CPU is held in reset until the whole image has been loaded.
//
// Optional feature macro: PROG_LOADER_CHKSUM_EN
//   When defined, an 8-bit running sum of all data bytes is kept. One extra
//   byte after the last word must equal that sum, otherwise the load ends in
//   the error state. When undefined, the last write goes straight to DONE.
//
// Parameters
//   BASE_ADDR      byte address of the first written word
//   MAX_WORDS      largest accepted word count (larger header -> error)
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   start          one-cycle pulse, starts a load from IDLE, DONE or ERR
//   byte_valid     byte_data holds a valid stream byte
//   byte_data      stream byte
//   byte_ready     loader accepts a byte this cycle (registered)
//   wr_en          one-cycle instruction-memory write strobe
//   wr_addr        word-aligned byte address of the write
//   wr_data        assembled instruction word
//   cpu_hold       CPU reset request, low only after a successful load
//   load_done      image loaded successfully
//   load_err       load aborted
//   words_written  words written during the current load
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
`ifdef PROG_LOADER_CHKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // State entered once the last word has been written (or for an empty
    // image): the checksum byte when the feature is built in, else DONE.
`ifdef PROG_LOADER_CHKSUM_EN
    localparam state_t S_FINISH = S_CHK;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    // Header counts are compared 17 bits wide so MAX_WORDS up to 65535 fits.
    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] word_q,  word_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [15:0] len_q,   len_d;
    logic [1:0]  idx_q,   idx_d;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0]  sum_q,   sum_d;
`endif

    logic        take;
    logic [15:0] lenFull;

    assign take    = byte_valid && ready_q;
    assign lenFull = {byte_data, len_q[7:0]};

    // Outputs are plain decodes of registered state so they come straight
    // out of flops and match the reset values without extra logic.
    assign byte_ready    = ready_q;
    assign wr_en         = (state_q == S_WRITE);
    assign wr_addr       = addr_q;
    assign wr_data       = word_q;
    assign cpu_hold      = (state_q != S_DONE);
    assign load_done     = (state_q == S_DONE);
    assign load_err      = (state_q == S_ERR);
    assign words_written = cnt_q;

    // State and datapath registers. Reset throws away any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            addr_q  <= BASE_ADDR;
            word_q  <= 32'h0;
            cnt_q   <= 16'h0;
            len_q   <= 16'h0;
            idx_q   <= 2'd0;
`ifdef PROG_LOADER_CHKSUM_EN
            sum_q   <= 8'h0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
`ifdef PROG_LOADER_CHKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Next-state and datapath updates. byte_ready is derived from the next
    // state so that it is already registered in the first cycle of a state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        idx_d   = idx_q;
`ifdef PROG_LOADER_CHKSUM_EN
        sum_d   = sum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // IDLE keeps the counters cleared; DONE/ERR clear on restart.
                if (state_q == S_IDLE || start) begin
                    addr_d = BASE_ADDR;
                    cnt_d  = 16'h0;
                    idx_d  = 2'd0;
`ifdef PROG_LOADER_CHKSUM_EN
                    sum_d  = 8'h0;
`endif
                end
                if (start) begin
                    state_d = S_LEN0;
                end
            end

            S_LEN0: begin
                if (take) begin
                    len_d[7:0] = byte_data;
                    state_d    = S_LEN1;
                end
            end

            S_LEN1: begin
                if (take) begin
                    len_d[15:8] = byte_data;
                    if ({1'b0, lenFull} > MAX_W) begin
                        state_d = S_ERR;
                    end else if (lenFull == 16'h0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (take) begin
                    case (idx_q)
                        2'd0:    word_d[7:0]   = byte_data;
                        2'd1:    word_d[15:8]  = byte_data;
                        2'd2:    word_d[23:16] = byte_data;
                        default: word_d[31:24] = byte_data;
                    endcase
                    idx_d = idx_q + 2'd1;
`ifdef PROG_LOADER_CHKSUM_EN
                    sum_d = sum_q + byte_data;
`endif
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                // The strobe is visible this cycle with the current address;
                // count and address advance together at the following edge.
                cnt_d  = cnt_q + 16'd1;
                addr_d = addr_q + 32'd4;
                if ((cnt_q + 16'd1) == len_q) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_DATA;
                end
            end

`ifdef PROG_LOADER_CHKSUM_EN
            S_CHK: begin
                if (take) begin
                    state_d = (byte_data == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
`ifdef PROG_LOADER_CHKSUM_EN
                  (state_d == S_CHK) ||
`endif
                  (state_d == S_DATA);
    end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader. Images are described as lists of
// 32-bit words; the bench turns them into a header plus little-endian byte
// stream, predicts the list of memory writes, the checksum byte and the final
// status, and compares against writes captured from the DUT.
// Honours PROG_LOADER_CHKSUM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_written;

    int          vecCount  = 0;
    int          failCount = 0;
    bit          toggleBit = 1'b0;
    logic [31:0] gotAddr[$];
    logic [31:0] gotData[$];

    prog_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_written(words_written)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the main sequence.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports misses.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Capture every write strobe; the stream must be stalled during a write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            gotAddr.push_back(wr_addr);
            gotData.push_back(wr_data);
            checkOutput("ready_low_in_write", 32'(byte_ready), 32'd0);
        end
    end

    // Present one byte until it is taken. mode 0: always valid,
    // 1: valid toggles every cycle, 2: valid random.
    task automatic applyStimulus(input logic [7:0] b, input int mode);
        bit acc   = 1'b0;
        int guard = 0;
        while (!acc && guard < 64) begin
            @(negedge clk);
            guard++;
            byte_data = b;
            case (mode)
                0:       byte_valid = 1'b1;
                1: begin
                    toggleBit  = ~toggleBit;
                    byte_valid = toggleBit;
                end
                default: byte_valid = 1'($urandom_range(0, 1));
            endcase
            acc = byte_valid && byte_ready;
        end
        if (!acc) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Full load of an image, with predicted writes and final status.
    task automatic runLoad(input string name, input logic [31:0] words[$],
                           input logic [15:0] hdr, input int mode,
                           input bit corruptChk, input bit pokeStart);
        logic [7:0] b;
        logic [7:0] sum        = 8'h0;
        bit         oversize   = (int'(hdr) > MAXW);
        bit         lastIsData = 1'b0;
        bit         expErr     = oversize;
        bit         seen       = 1'b0;
        int         cyc        = 0;
        int         expWrites  = oversize ? 0 : words.size();

        gotAddr.delete();
        gotData.delete();
        pulseStart();
        checkOutput({name, "_start_done"}, 32'(load_done), 32'd0);
        checkOutput({name, "_start_err"},  32'(load_err),  32'd0);
        checkOutput({name, "_start_hold"}, 32'(cpu_hold),  32'd1);
        checkOutput({name, "_start_cnt"},  32'(words_written), 32'd0);
        checkOutput({name, "_start_addr"}, wr_addr, BASE);

        applyStimulus(hdr[7:0], mode);
        applyStimulus(hdr[15:8], mode);
        if (!oversize) begin
            foreach (words[i]) begin
                for (int k = 0; k < 4; k++) begin
                    b   = words[i][8*k +: 8];
                    sum = sum + b;
                    if (pokeStart && i == 0 && k == 2) pulseStart();
                    applyStimulus(b, mode);
                    lastIsData = 1'b1;
                end
            end
`ifdef PROG_LOADER_CHKSUM_EN
            applyStimulus(corruptChk ? sum + 8'h1 : sum, mode);
            lastIsData = 1'b0;
            expErr     = corruptChk;
`endif
        end

        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) byte_valid = 1'b0;
            if (load_done === 1'b1 || load_err === 1'b1) begin
                seen = 1'b1;
                cyc  = c;
            end
        end
        checkOutput({name, "_latency"}, 32'(cyc), lastIsData ? 32'd2 : 32'd1);
        @(negedge clk);
        checkOutput({name, "_done"},  32'(load_done), 32'(!expErr));
        checkOutput({name, "_err"},   32'(load_err),  32'(expErr));
        checkOutput({name, "_hold"},  32'(cpu_hold),  32'(expErr));
        checkOutput({name, "_ready"}, 32'(byte_ready), 32'd0);
        checkOutput({name, "_cnt"},   32'(words_written), 32'(expWrites));
        checkOutput({name, "_nwrites"}, 32'(gotAddr.size()), 32'(expWrites));
        for (int i = 0; i < expWrites && i < gotAddr.size(); i++) begin
            checkOutput({name, "_addr"}, gotAddr[i], BASE + 32'(4 * i));
            checkOutput({name, "_data"}, gotData[i], words[i]);
        end
    endtask

    initial begin
        logic [31:0] img[$];
        logic [31:0] rimg[$];
        logic [31:0] none[$];
        int          n;

        img  = '{32'h341C_E137, 32'hF0C1_0113};
        none = {};
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        // Reset values with no stimulus.
        repeat (3) @(negedge clk);
        checkOutput("rst_hold",  32'(cpu_hold),   32'd1);
        checkOutput("rst_ready", 32'(byte_ready), 32'd0);
        checkOutput("rst_wren",  32'(wr_en),      32'd0);
        checkOutput("rst_done",  32'(load_done),  32'd0);
        checkOutput("rst_err",   32'(load_err),   32'd0);
        checkOutput("rst_addr",  wr_addr,         BASE);
        checkOutput("rst_data",  wr_data,         32'd0);
        checkOutput("rst_cnt",   32'(words_written), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_ready", 32'(byte_ready), 32'd0);
        checkOutput("idle_hold",  32'(cpu_hold),   32'd1);

        // Reference image, continuous then with valid toggling and a stray start.
        runLoad("img_cont",   img, 16'd2, 0, 1'b0, 1'b0);
        runLoad("img_toggle", img, 16'd2, 1, 1'b0, 1'b1);

        // Header count above the limit, then recovery with a good image.
        runLoad("oversize", none, 16'd1025, 0, 1'b0, 1'b0);
        runLoad("recover",  img,  16'd2,    2, 1'b0, 1'b0);

`ifdef PROG_LOADER_CHKSUM_EN
        runLoad("bad_chk", img, 16'd2, 0, 1'b1, 1'b0);
`endif

        // Reset after six data bytes: only word 0 has been written.
        gotAddr.delete();
        gotData.delete();
        pulseStart();
        applyStimulus(8'h02, 0);
        applyStimulus(8'h00, 0);
        for (int k = 0; k < 6; k++) begin
            n = k / 4;
            applyStimulus(img[n][8*(k%4) +: 8], 0);
        end
        @(negedge clk);
        rst        = 1'b1;
        byte_valid = 1'b0;
        #1;
        checkOutput("midrst_hold",  32'(cpu_hold),   32'd1);
        checkOutput("midrst_ready", 32'(byte_ready), 32'd0);
        checkOutput("midrst_wren",  32'(wr_en),      32'd0);
        checkOutput("midrst_addr",  wr_addr,         BASE);
        checkOutput("midrst_wdata", wr_data,         32'd0);
        checkOutput("midrst_cnt",   32'(words_written), 32'd0);
        checkOutput("midrst_done",  32'(load_done),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_nwrites", 32'(gotAddr.size()), 32'd1);
        if (gotAddr.size() > 0) begin
            checkOutput("midrst_w0addr", gotAddr[0], BASE);
            checkOutput("midrst_w0data", gotData[0], img[0]);
        end

        // Empty image.
        runLoad("empty", none, 16'd0, 0, 1'b0, 1'b0);

        // Random images with random valid gaps.
        for (int t = 0; t < 6; t++) begin
            rimg.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) rimg.push_back($urandom);
            runLoad("random", rimg, 16'(n), 2, 1'b0, 1'b0);
        end

        // Largest accepted image.
        rimg.delete();
        for (int i = 0; i < MAXW; i++) rimg.push_back($urandom);
        runLoad("max_words", rimg, 16'(MAXW), 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
